// File: rtl/mesi_pkg.sv
// rtl/mesi_pkg.sv - MESI line states, control FSM states and next-state rules
package mesi_pkg;

    typedef enum logic [1:0] {
        ST_I = 2'b00,
        ST_S = 2'b01,
        ST_E = 2'b10,
        ST_M = 2'b11
    } mesi_t;

    typedef enum logic {
        FSM_IDLE  = 1'b0,
        FSM_FLUSH = 1'b1
    } fsm_t;

    // A processor write always ends in M; a read miss fills S or E depending on other sharers.
    function automatic mesi_t proc_next_state(mesi_t cur, logic hit, logic rw, logic shared);
        if (rw)
            return ST_M;
        else if (hit)
            return cur;
        else
            return shared ? ST_S : ST_E;
    endfunction

    function automatic mesi_t snoop_next_state(mesi_t cur, logic hit, logic rw);
        if (!hit)
            return cur;
        else if (rw)
            return ST_I;
        else
            return ST_S;
    endfunction

endpackage

// File: rtl/mesi_snoop_dir_if.sv
// rtl/mesi_snoop_dir_if.sv - processor, snoop and flush signals of the MESI directory
interface mesi_snoop_dir_if #(
    parameter int ADDR_W = 24
);
    logic              P_VALID;
    logic              P_RW;
    logic [ADDR_W-1:0] P_ADDR;
    logic              P_SHARED;
    logic              P_READY;
    logic              P_RESP;
    logic              P_HIT;
    logic              P_BUSRDX;
    logic              S_VALID;
    logic              S_RW;
    logic [ADDR_W-1:0] S_ADDR;
    logic              S_READY;
    logic              S_RESP;
    logic              S_HIT;
    logic [1:0]        S_STATUS;
    logic              FLUSH_REQ;
    logic [ADDR_W-1:0] FLUSH_ADDR;
    logic              FLUSH_ACK;

    modport slave (
        input  P_VALID, P_RW, P_ADDR, P_SHARED, S_VALID, S_RW, S_ADDR, FLUSH_ACK,
        output P_READY, P_RESP, P_HIT, P_BUSRDX, S_READY, S_RESP, S_HIT, S_STATUS,
               FLUSH_REQ, FLUSH_ADDR
    );

    modport master (
        output P_VALID, P_RW, P_ADDR, P_SHARED, S_VALID, S_RW, S_ADDR, FLUSH_ACK,
        input  P_READY, P_RESP, P_HIT, P_BUSRDX, S_READY, S_RESP, S_HIT, S_STATUS,
               FLUSH_REQ, FLUSH_ADDR
    );
endinterface

// File: rtl/mesi_dir_array.sv
// rtl/mesi_dir_array.sv - direct-mapped tag and MESI state storage, async read, one write port
module mesi_dir_array
    import mesi_pkg::*;
#(
    parameter int TAG_W = 16,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output mesi_t            rd_state,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  mesi_t            wr_state
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [TAG_W-1:0] tags   [DEPTH];
    mesi_t            states [DEPTH];

    assign rd_tag   = tags[rd_idx];
    assign rd_state = states[rd_idx];

    // Tags need no reset: a line in I never reports a hit.
    always_ff @(posedge clk) begin
        if (we)
            tags[wr_idx] <= wr_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                states[i] <= ST_I;
        end else if (we) begin
            states[wr_idx] <= wr_state;
        end
    end
endmodule

// File: rtl/mesi_snoop_dir.sv
// rtl/mesi_snoop_dir.sv - MESI directory top: arbitration, control FSM, registered responses
module mesi_snoop_dir
    import mesi_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int IDX_W  = 8
) (
    input  logic             SCLK,
    input  logic             SRST,
    mesi_snoop_dir_if.slave  bus
);
    localparam int TAG_W = ADDR_W - IDX_W;

    fsm_t              fsm;
    fsm_t              fsm_nxt;
    logic              idle;
    logic              s_acc;
    logic              p_acc;
    logic [ADDR_W-1:0] lk_addr;
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [TAG_W-1:0]  rd_tag;
    mesi_t             rd_state;
    mesi_t             wr_state;
    logic              lk_hit;
    logic              wr_en;
    logic              need_flush;

    // Snoop has priority; the single lookup port follows whichever side may win.
    assign idle    = (fsm == FSM_IDLE) && !SRST;
    assign s_acc   = idle && bus.S_VALID;
    assign p_acc   = idle && !bus.S_VALID && bus.P_VALID;
    assign lk_addr = bus.S_VALID ? bus.S_ADDR : bus.P_ADDR;
    assign lk_idx  = lk_addr[IDX_W-1:0];
    assign lk_tag  = lk_addr[ADDR_W-1:IDX_W];
    assign lk_hit  = (rd_state != ST_I) && (rd_tag == lk_tag);

    assign wr_en    = (s_acc && lk_hit) || p_acc;
    assign wr_state = s_acc ? snoop_next_state(rd_state, lk_hit, bus.S_RW)
                            : proc_next_state(rd_state, lk_hit, bus.P_RW, bus.P_SHARED);
    // Dirty data leaves on a snoop hit in M, or when a processor miss evicts an M victim.
    assign need_flush = (rd_state == ST_M) && ((s_acc && lk_hit) || (p_acc && !lk_hit));

    mesi_dir_array #(
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_array (
        .clk      (SCLK),
        .rst      (SRST),
        .rd_idx   (lk_idx),
        .rd_tag   (rd_tag),
        .rd_state (rd_state),
        .we       (wr_en),
        .wr_idx   (lk_idx),
        .wr_tag   (lk_tag),
        .wr_state (wr_state)
    );

    always_ff @(posedge SCLK) begin
        if (SRST)
            fsm <= FSM_IDLE;
        else
            fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            FSM_IDLE:  if (need_flush)    fsm_nxt = FSM_FLUSH;
            FSM_FLUSH: if (bus.FLUSH_ACK) fsm_nxt = FSM_IDLE;
            default:                      fsm_nxt = FSM_IDLE;
        endcase
    end

    always_comb begin
        bus.S_READY   = idle;
        bus.P_READY   = idle && !bus.S_VALID;
        bus.FLUSH_REQ = (fsm == FSM_FLUSH);
    end

    always_ff @(posedge SCLK) begin
        if (SRST) begin
            bus.P_RESP     <= 1'b0;
            bus.P_HIT      <= 1'b0;
            bus.P_BUSRDX   <= 1'b0;
            bus.S_RESP     <= 1'b0;
            bus.S_HIT      <= 1'b0;
            bus.S_STATUS   <= ST_I;
            bus.FLUSH_ADDR <= '0;
        end else begin
            bus.P_RESP   <= p_acc;
            bus.P_HIT    <= p_acc && lk_hit;
            bus.P_BUSRDX <= p_acc && bus.P_RW && (!lk_hit || rd_state == ST_S);
            bus.S_RESP   <= s_acc;
            bus.S_HIT    <= s_acc && lk_hit;
            bus.S_STATUS <= (s_acc && lk_hit) ? rd_state : ST_I;
            if (need_flush)
                bus.FLUSH_ADDR <= s_acc ? bus.S_ADDR : {rd_tag, lk_idx};
        end
    end
endmodule

// File: tb/tb_mesi_snoop_dir.sv
// tb/tb_mesi_snoop_dir.sv - directed and randomized checks of mesi_snoop_dir against a line-table model
module tb_mesi_snoop_dir;
    logic SCLK = 1'b0;
    logic SRST = 1'b1;
    always #5 SCLK = ~SCLK;

    mesi_snoop_dir_if #(.ADDR_W(24)) bus ();

    mesi_snoop_dir #(.ADDR_W(24), .IDX_W(8)) dut (
        .SCLK (SCLK),
        .SRST (SRST),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    bit armed  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one entry per line, 0=I 1=S 2=E 3=M, plus the pending write-back.
    bit [15:0] m_tag [256];
    bit [1:0]  m_st  [256];
    bit        m_flush;
    bit [23:0] m_faddr;
    bit        e_presp, e_phit, e_pbusrdx, e_sresp, e_shit;
    bit [1:0]  e_sstat;

    always @(posedge SCLK) begin
        bit [7:0]  idx;
        bit [15:0] t;
        bit [1:0]  cur;
        bit        hit;
        e_presp = 0; e_phit = 0; e_pbusrdx = 0; e_sresp = 0; e_shit = 0; e_sstat = 0;
        if (SRST) begin
            for (int i = 0; i < 256; i++) m_st[i] = 0;
            m_flush = 0;
        end else if (m_flush) begin
            if (bus.FLUSH_ACK) m_flush = 0;
        end else if (bus.S_VALID) begin
            idx = bus.S_ADDR[7:0];
            t   = bus.S_ADDR[23:8];
            cur = m_st[idx];
            hit = (cur != 0) && (m_tag[idx] == t);
            e_sresp = 1;
            e_shit  = hit;
            e_sstat = hit ? cur : 2'd0;
            if (hit) begin
                if (cur == 3) begin m_flush = 1; m_faddr = bus.S_ADDR; end
                m_st[idx] = bus.S_RW ? 2'd0 : 2'd1;
            end
        end else if (bus.P_VALID) begin
            idx = bus.P_ADDR[7:0];
            t   = bus.P_ADDR[23:8];
            cur = m_st[idx];
            hit = (cur != 0) && (m_tag[idx] == t);
            e_presp   = 1;
            e_phit    = hit;
            e_pbusrdx = bus.P_RW && (!hit || cur == 1);
            if (!hit && cur == 3) begin m_flush = 1; m_faddr = {m_tag[idx], idx}; end
            if (!hit) begin
                m_tag[idx] = t;
                m_st[idx]  = bus.P_RW ? 2'd3 : (bus.P_SHARED ? 2'd1 : 2'd2);
            end else if (bus.P_RW) begin
                m_st[idx] = 3;
            end
        end
    end

    always @(negedge SCLK) begin
        if (armed) begin
            chk("s_ready", bus.S_READY, !SRST && !m_flush);
            chk("p_ready", bus.P_READY, !SRST && !m_flush && !bus.S_VALID);
            chk("flush_req", bus.FLUSH_REQ, m_flush);
            if (m_flush) chk("flush_addr", bus.FLUSH_ADDR, m_faddr);
            chk("p_resp", bus.P_RESP, e_presp);
            chk("s_resp", bus.S_RESP, e_sresp);
            if (e_presp) begin
                chk("p_hit", bus.P_HIT, e_phit);
                chk("p_busrdx", bus.P_BUSRDX, e_pbusrdx);
            end
            if (e_sresp) begin
                chk("s_hit", bus.S_HIT, e_shit);
                chk("s_status", bus.S_STATUS, e_sstat);
            end
        end
    end

    task automatic pacc(input bit rw, input bit [23:0] addr, input bit sh);
        bus.P_VALID = 1; bus.P_RW = rw; bus.P_ADDR = addr; bus.P_SHARED = sh;
        @(posedge SCLK); #1;
        bus.P_VALID = 0;
        #1;
    endtask

    task automatic sacc(input bit rw, input bit [23:0] addr);
        bus.S_VALID = 1; bus.S_RW = rw; bus.S_ADDR = addr;
        @(posedge SCLK); #1;
        bus.S_VALID = 0;
        #1;
    endtask

    task automatic next_cyc();
        @(posedge SCLK); #2;
    endtask

    function automatic bit [23:0] rand_addr();
        bit [15:0] t;
        bit [7:0]  i;
        case ($urandom_range(0, 2))
            0: t = 16'h0012;
            1: t = 16'h00AB;
            default: t = 16'h0001;
        endcase
        case ($urandom_range(0, 2))
            0: i = 8'h34;
            1: i = 8'h35;
            default: i = 8'h50;
        endcase
        return {t, i};
    endfunction

    initial begin
        bus.P_VALID = 0; bus.P_RW = 0; bus.P_ADDR = 0; bus.P_SHARED = 0;
        bus.S_VALID = 0; bus.S_RW = 0; bus.S_ADDR = 0; bus.FLUSH_ACK = 0;
        repeat (2) @(posedge SCLK);
        #1;
        armed = 1;
        chk("rst_p_resp", bus.P_RESP, 0);
        chk("rst_flush_req", bus.FLUSH_REQ, 0);
        chk("rst_s_ready", bus.S_READY, 0);
        SRST = 0;
        #1;

        // Read fill in E, then snoop reads demote it to S.
        pacc(0, 24'h001234, 0);
        chk("t1_p_resp", bus.P_RESP, 1);
        chk("t1_p_hit", bus.P_HIT, 0);
        sacc(0, 24'h001234);
        chk("t1_s_hit", bus.S_HIT, 1);
        chk("t1_s_status_e", bus.S_STATUS, 2'b10);
        sacc(0, 24'h001234);
        chk("t1_s_status_s", bus.S_STATUS, 2'b01);

        // Write hit in S upgrades to M; snoop read forces a flush held until ACK.
        pacc(1, 24'h001234, 1);
        chk("t2_p_hit", bus.P_HIT, 1);
        chk("t2_p_busrdx", bus.P_BUSRDX, 1);
        sacc(0, 24'h001234);
        chk("t2_s_status_m", bus.S_STATUS, 2'b11);
        chk("t2_flush_req", bus.FLUSH_REQ, 1);
        chk("t2_flush_addr", bus.FLUSH_ADDR, 24'h001234);
        repeat (3) begin
            next_cyc();
            chk("t2_req_held", bus.FLUSH_REQ, 1);
            chk("t2_s_ready_low", bus.S_READY, 0);
        end
        bus.FLUSH_ACK = 1;
        @(posedge SCLK); #1;
        bus.FLUSH_ACK = 0;
        #1;
        chk("t2_req_dropped", bus.FLUSH_REQ, 0);
        chk("t2_s_ready_back", bus.S_READY, 1);

        // Victim write-back of an M line on a conflicting read miss.
        pacc(1, 24'h001234, 0);
        pacc(0, 24'h00AB34, 1);
        chk("t3_p_hit", bus.P_HIT, 0);
        chk("t3_flush_req", bus.FLUSH_REQ, 1);
        chk("t3_victim_addr", bus.FLUSH_ADDR, 24'h001234);
        bus.FLUSH_ACK = 1;
        @(posedge SCLK); #1;
        bus.FLUSH_ACK = 0;
        #1;
        sacc(0, 24'h00AB34);
        chk("t3_s_status", bus.S_STATUS, 2'b01);

        // Simultaneous requests: snoop wins, processor goes next cycle.
        bus.S_VALID = 1; bus.S_RW = 0; bus.S_ADDR = 24'h000100;
        bus.P_VALID = 1; bus.P_RW = 0; bus.P_ADDR = 24'h000200; bus.P_SHARED = 0;
        #1;
        chk("t4_s_ready", bus.S_READY, 1);
        chk("t4_p_ready", bus.P_READY, 0);
        @(posedge SCLK); #1;
        bus.S_VALID = 0;
        #1;
        chk("t4_s_resp", bus.S_RESP, 1);
        chk("t4_p_resp_wait", bus.P_RESP, 0);
        chk("t4_p_ready_now", bus.P_READY, 1);
        @(posedge SCLK); #1;
        bus.P_VALID = 0;
        #1;
        chk("t4_p_resp", bus.P_RESP, 1);

        // Bus write on an E line: invalidate without write-back.
        pacc(0, 24'h000550, 0);
        sacc(1, 24'h000550);
        chk("t5_s_status_e", bus.S_STATUS, 2'b10);
        chk("t5_no_flush", bus.FLUSH_REQ, 0);
        pacc(0, 24'h000550, 0);
        chk("t5_p_miss", bus.P_HIT, 0);

        // Reset while flushing abandons the write-back and clears all lines.
        pacc(1, 24'h000660, 0);
        sacc(1, 24'h000660);
        chk("t6_flush_req", bus.FLUSH_REQ, 1);
        SRST = 1;
        @(posedge SCLK); #1;
        chk("t6_req_cleared", bus.FLUSH_REQ, 0);
        SRST = 0;
        #1;
        sacc(0, 24'h000660);
        chk("t6_s_miss", bus.S_HIT, 0);
        pacc(0, 24'h00AB34, 0);
        chk("t6_p_miss", bus.P_HIT, 0);

        // Randomized traffic over a few contended lines.
        repeat (3000) begin
            @(posedge SCLK); #1;
            SRST          = ($urandom_range(0, 399) == 0);
            bus.P_VALID   = $urandom_range(0, 1);
            bus.P_RW      = $urandom_range(0, 1);
            bus.P_ADDR    = rand_addr();
            bus.P_SHARED  = $urandom_range(0, 1);
            bus.S_VALID   = ($urandom_range(0, 3) == 0);
            bus.S_RW      = $urandom_range(0, 1);
            bus.S_ADDR    = rand_addr();
            bus.FLUSH_ACK = ($urandom_range(0, 2) == 0);
        end
        @(posedge SCLK); #1;
        SRST = 0; bus.P_VALID = 0; bus.S_VALID = 0; bus.FLUSH_ACK = 0;
        repeat (3) @(posedge SCLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mesi_snoop_dir.md
Name: mesi_snoop_dir

Overview:
- Parametrised, direct-mapped MESI directory (tag + 2-bit state per line). It serves one processor port and one bus-snoop port.
- Replaces the fixed 24-bit/256-line MSI-style status lookup.
- Adds:
  - full MESI transitions;
  - processor-side allocation;
  - victim and snoop write-back (flush) requests with a handshake;
  - registered responses.
- Sits between the processor/L1 controller and the shared bus arbiter.

Parameters:
- ADDR_W, 24, line-address width (tag = ADDR_W-IDX_W bits).
- IDX_W, 8, index width; depth = 2**IDX_W lines.

Ports:
- SCLK  in  1  clock, all logic on rising edge.
- SRST  in  1  reset, synchronous, active-high.
- P_VALID  in  1  processor access request.
- P_RW  in  1  1=write, 0=read.
- P_ADDR  in  ADDR_W  processor line address.
- P_SHARED  in  1  bus reports another sharer (used on read-miss fill).
- P_READY  out  1  processor request accepted this cycle.
- P_RESP  out  1  processor response valid (one-cycle pulse).
- P_HIT  out  1  lookup hit (tag match and state != I).
- P_BUSRDX  out  1  write needs a bus invalidate (write miss, or write hit in S).
- S_VALID  in  1  snoop request.
- S_RW  in  1  1=bus write/RdX, 0=bus read.
- S_ADDR  in  ADDR_W  snooped line address.
- S_READY  out  1  snoop accepted this cycle.
- S_RESP  out  1  snoop response valid (one-cycle pulse).
- S_HIT  out  1  snoop hit.
- S_STATUS  out  2  state of the line before the snoop transition (I on miss).
- FLUSH_REQ  out  1  write-back request to the bus.
- FLUSH_ADDR  out  ADDR_W  line address to write back.
- FLUSH_ACK  in  1  bus has taken the write-back.

Behaviour:
- State encoding: I=00, S=01, E=10, M=11.
- Control FSM states: IDLE, FLUSH.
- Reset:
  - all line states become I; tags are don't-care;
  - FSM goes to IDLE;
  - every output is 0;
  - a reset during FLUSH abandons the pending flush, and FLUSH_REQ drops the next cycle.
- Acceptance:
  - S_READY = (FSM==IDLE).
  - P_READY = (FSM==IDLE) && !S_VALID. Snoop wins a simultaneous request; the processor must hold its request.
  - In FLUSH both READYs are 0.
- Latency: the lookup and the state/tag update happen at the acceptance edge. P_RESP/S_RESP and their data fields are registered outputs, valid exactly one cycle after acceptance.
- Processor transitions:
  - read hit: no change.
  - read miss: tag written; state = P_SHARED ? S : E.
  - write hit in E or M: becomes M, P_BUSRDX=0.
  - write hit in S: becomes M, P_BUSRDX=1.
  - write miss: tag written; state = M; P_BUSRDX=1.
- Victim handling: on a miss where the old line is M with a different tag, FLUSH_ADDR = {old tag, index} and the FSM enters FLUSH.
- Snoop transitions (hit only; a miss changes nothing and reports S_STATUS=I):
  - bus read: M becomes S (flush required); E becomes S; S stays S.
  - bus write: any state becomes I; from M a flush is required.
  - Snoop flush uses FLUSH_ADDR = S_ADDR.
- Flush handshake:
  - FLUSH_REQ rises in the cycle after acceptance (alongside RESP) and is held, with FLUSH_ADDR stable, until FLUSH_ACK is sampled high.
  - FLUSH_REQ is 0 in the cycle after the ACK, and the FSM returns to IDLE.
  - FLUSH_ACK is ignored while FLUSH_REQ=0.
- Same-index back-to-back accesses see the updated state (write-first array).
- Index/tag split: index = ADDR[IDX_W-1:0]; tag = ADDR[ADDR_W-1:IDX_W].

Decomposition:
- Package mesi_pkg:
  - state typedef/localparams (I, S, E, M);
  - FSM state localparams;
  - pure functions snoop_next_state and proc_next_state.
- Sub-module mesi_dir_array: tag + state storage with one read index and one write port. It has a synchronous clear of all states driven by SRST.
- The top level holds the FSM, acceptance arbitration and response registers.

Test Plan:
- Reset, then read P_ADDR=24'h0012_34 with P_SHARED=0 → P_RESP next cycle, P_HIT=0. A snoop read of the same address then gives S_HIT=1 and S_STATUS=E; a second snoop read gives S_STATUS=S.
- Write 24'h0012_34 after a read fill with P_SHARED=1 → P_HIT=1, P_BUSRDX=1. A following snoop read gives S_STATUS=M, FLUSH_REQ=1 with FLUSH_ADDR=24'h0012_34; hold ACK low 3 cycles → REQ stays high and S_READY=0; ACK → REQ low the next cycle.
- Line 8'h34 in M with tag 16'h0012, then processor read of 24'h00AB_34 → FLUSH_ADDR=24'h0012_34. A snoop of 24'h00AB_34 then reports S or E per P_SHARED.
- S_VALID and P_VALID high in the same IDLE cycle → S_READY=1, P_READY=0. The processor is accepted the next cycle.
- Snoop bus write on an E line → S_STATUS=E, no FLUSH_REQ. A later processor read misses (P_HIT=0).
- Assert SRST during FLUSH → FLUSH_REQ=0 the next cycle. All subsequent lookups miss.
